// File: rtl/mem_access_pkg.sv
// Shared widths, write-back bundle type and SRAM FSM state encodings for the MEM stage.
package mem_access_pkg;

    localparam int REG_VALUE_W = 16;
    localparam int REG_ADDR_W  = 4;
    localparam int CNT_W       = 8;

    typedef logic [REG_VALUE_W-1:0] reg_value_t;
    typedef logic [REG_ADDR_W-1:0]  reg_addr_t;

    typedef struct packed {
        reg_value_t value;
        logic       reg_write;
        reg_addr_t  reg_addr;
    } wb_bundle_t;

    localparam logic [2:0] MEM_IDLE     = 3'd0;
    localparam logic [2:0] MEM_RD       = 3'd1;
    localparam logic [2:0] MEM_WR_SETUP = 3'd2;
    localparam logic [2:0] MEM_WR_PULSE = 3'd3;
    localparam logic [2:0] MEM_WR_HOLD  = 3'd4;

endpackage

// File: rtl/mem_access_sram_ctrl.sv
// External SRAM (RAM1) access sequencer: FSM, wait counter, control pins and data tri-state.
//   state        | meaning
//   MEM_IDLE     | no access; accepts req_rd (priority) or req_wr
//   MEM_RD       | OE/EN low for RD_WAIT cycles, data sampled at the last edge
//   MEM_WR_SETUP | address/data settle with WE high
//   MEM_WR_PULSE | WE low for WR_WAIT cycles
//   MEM_WR_HOLD  | WE high, data still driven; last cycle of a write
module mem_access_sram_ctrl
    import mem_access_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1,
    parameter int RAM_AW  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  reg_value_t        addr,
    input  reg_value_t        wdata,
    output reg_value_t        rdata,
    output logic              last,
    output logic              busy,
    output logic [RAM_AW-1:0] ram_addr,
    inout  wire  [15:0]       ram_data,
    output logic              ram_en_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    reg_value_t       addr_q;
    reg_value_t       wdata_q;
    logic             drive;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MEM_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (req_rd) begin
                        state  <= MEM_RD;
                        cnt    <= CNT_W'(RD_WAIT - 1);
                        addr_q <= addr;
                    end else if (req_wr) begin
                        state   <= MEM_WR_SETUP;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                    end
                end
                MEM_RD: begin
                    if (cnt == '0) state <= MEM_IDLE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                MEM_WR_SETUP: begin
                    state <= MEM_WR_PULSE;
                    cnt   <= CNT_W'(WR_WAIT - 1);
                end
                MEM_WR_PULSE: begin
                    if (cnt == '0) state <= MEM_WR_HOLD;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                MEM_WR_HOLD: state <= MEM_IDLE;
                default:     state <= MEM_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_en_n = 1'b1;
        ram_oe_n = 1'b1;
        ram_we_n = 1'b1;
        drive    = 1'b0;
        case (state)
            MEM_RD: begin
                ram_en_n = 1'b0;
                ram_oe_n = 1'b0;
            end
            MEM_WR_SETUP: begin
                ram_en_n = 1'b0;
                drive    = 1'b1;
            end
            MEM_WR_PULSE: begin
                ram_en_n = 1'b0;
                ram_we_n = 1'b0;
                drive    = 1'b1;
            end
            MEM_WR_HOLD: begin
                ram_en_n = 1'b0;
                drive    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (state != MEM_IDLE);
    assign last     = ((state == MEM_RD) && (cnt == '0)) || (state == MEM_WR_HOLD);
    assign ram_addr = busy ? RAM_AW'(addr_q) : '0;
    // Bus is only driven in write states, where OE is always high.
    assign ram_data = drive ? wdata_q : 16'hzzzz;
    assign rdata    = ram_data;

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: launches SRAM loads/stores, stalls upstream, registers the write-back bundle.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1,
    parameter int RAM_AW  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  reg_value_t        alu_result,
    input  reg_value_t        mem_write_value,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  reg_addr_t         reg_addr,
    output logic              stall,
    output reg_value_t        wb_value_out,
    output logic              reg_write_out,
    output reg_addr_t         reg_addr_out,
    output logic [RAM_AW-1:0] ram_addr,
    inout  wire  [15:0]       ram_data,
    output logic              ram_en_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    wb_bundle_t wb_q;
    reg_value_t rdata;
    logic       last;
    logic       busy;
    logic       req;
    logic       rd_pend;
    logic       rd_reg_write;
    reg_addr_t  rd_reg_addr;

    mem_access_sram_ctrl #(
        .RD_WAIT (RD_WAIT),
        .WR_WAIT (WR_WAIT),
        .RAM_AW  (RAM_AW)
    ) u_sram_ctrl (
        .clk      (clk),
        .rst      (rst),
        .req_rd   (mem_read),
        .req_wr   (mem_write),
        .addr     (alu_result),
        .wdata    (mem_write_value),
        .rdata    (rdata),
        .last     (last),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_en_n (ram_en_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n)
    );

    assign req = mem_read | mem_write;
    // Stall drops in the last access cycle so upstream advances as the FSM returns to idle.
    assign stall = ~rst & (busy ? ~last : req);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q         <= '0;
            rd_pend      <= 1'b0;
            rd_reg_write <= 1'b0;
            rd_reg_addr  <= '0;
        end else if (!busy) begin
            if (req) begin
                wb_q.reg_write <= 1'b0;
                rd_pend        <= mem_read;
                rd_reg_write   <= reg_write;
                rd_reg_addr    <= reg_addr;
            end else begin
                wb_q <= '{value: alu_result, reg_write: reg_write, reg_addr: reg_addr};
            end
        end else if (last && rd_pend) begin
            wb_q    <= '{value: rdata, reg_write: rd_reg_write, reg_addr: rd_reg_addr};
            rd_pend <= 1'b0;
        end else begin
            wb_q.reg_write <= 1'b0;
        end
    end

    assign wb_value_out  = wb_q.value;
    assign reg_write_out = wb_q.reg_write;
    assign reg_addr_out  = wb_q.reg_addr;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a behavioural async SRAM model on the data bus.
module tb_mem_access;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 1;
    localparam int RAM_AW  = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       alu_result;
    logic [15:0]       mem_write_value;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic [3:0]        reg_addr;
    logic              stall;
    logic [15:0]       wb_value_out;
    logic              reg_write_out;
    logic [3:0]        reg_addr_out;
    logic [RAM_AW-1:0] ram_addr;
    wire  [15:0]       ram_data;
    logic              ram_en_n;
    logic              ram_oe_n;
    logic              ram_we_n;

    logic [15:0] mem [0:(1<<RAM_AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access #(
        .RD_WAIT (RD_WAIT),
        .WR_WAIT (WR_WAIT),
        .RAM_AW  (RAM_AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_result      (alu_result),
        .mem_write_value (mem_write_value),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .reg_write       (reg_write),
        .reg_addr        (reg_addr),
        .stall           (stall),
        .wb_value_out    (wb_value_out),
        .reg_write_out   (reg_write_out),
        .reg_addr_out    (reg_addr_out),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .ram_en_n        (ram_en_n),
        .ram_oe_n        (ram_oe_n),
        .ram_we_n        (ram_we_n)
    );

    assign ram_data = (!ram_en_n && !ram_oe_n && ram_we_n) ? mem[ram_addr] : 16'hzzzz;

    always @(posedge clk)
        if (!ram_en_n && !ram_we_n) mem[ram_addr] <= ram_data;

    typedef struct {
        logic [15:0] alu;
        logic        rw;
        logic [3:0]  ra;
        logic [15:0] exp_wb;
        logic        exp_rw;
        logic [3:0]  exp_ra;
    } pt_vec_t;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] wval;
        logic        rd;
        logic        wr;
        logic        rw;
        logic [3:0]  ra;
    } instr_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [15:0] alu, input logic [15:0] wval, input logic rd,
                          input logic wr, input logic rw, input logic [3:0] ra);
        alu_result      = alu;
        mem_write_value = wval;
        mem_read        = rd;
        mem_write       = wr;
        reg_write       = rw;
        reg_addr        = ra;
    endtask

    function automatic logic [31:0] ctrl();
        return {29'd0, ram_en_n, ram_oe_n, ram_we_n};
    endfunction

    pt_vec_t pt_vecs [4];
    instr_t  prog [3];

    initial begin
        pt_vecs[0] = '{16'h1234, 1'b1, 4'h3, 16'h1234, 1'b1, 4'h3};
        pt_vecs[1] = '{16'hFFFF, 1'b0, 4'hF, 16'hFFFF, 1'b0, 4'hF};
        pt_vecs[2] = '{16'h0000, 1'b1, 4'h0, 16'h0000, 1'b1, 4'h0};
        pt_vecs[3] = '{16'h8001, 1'b1, 4'h7, 16'h8001, 1'b1, 4'h7};

        prog[0] = '{16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h1};
        prog[1] = '{16'h0200, 16'h5A5A, 1'b0, 1'b1, 1'b0, 4'h0};
        prog[2] = '{16'h0333, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0};

        mem[18'h08000] = 16'hBEEF;
        mem[18'h00100] = 16'hCAFE;
        mem[18'h00200] = 16'h0000;
        mem[18'h00300] = 16'h1357;
        mem[18'h04010] = 16'h0000;
        mem[18'h00500] = 16'h0000;

        // Reset with a pending read request: nothing may start, stall held low
        rst = 1'b1;
        set_in(16'h9999, 16'h0, 1'b1, 1'b0, 1'b1, 4'h9);
        tick();
        tick();
        check("rst_stall", stall, 0);
        check("rst_wb", wb_value_out, 0);
        check("rst_rw", reg_write_out, 0);
        check("rst_ra", reg_addr_out, 0);
        check("rst_ctrl", ctrl(), 3'b111);
        check("rst_addr", ram_addr, 0);
        set_in(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            set_in(pt_vecs[i].alu, 16'h0, 1'b0, 1'b0, pt_vecs[i].rw, pt_vecs[i].ra);
            #1;
            check("pt_stall", stall, 0);
            check("pt_ctrl", ctrl(), 3'b111);
            tick();
            check("pt_wb", wb_value_out, pt_vecs[i].exp_wb);
            check("pt_rw", reg_write_out, pt_vecs[i].exp_rw);
            check("pt_ra", reg_addr_out, pt_vecs[i].exp_ra);
        end

        // Load from 0x8000
        set_in(16'h8000, 16'h0, 1'b1, 1'b0, 1'b1, 4'h5);
        #1;
        check("ld_req_stall", stall, 1);
        tick();
        check("ld_bubble", reg_write_out, 0);
        check("ld_ctrl1", ctrl(), 3'b001);
        check("ld_addr", ram_addr, 18'h08000);
        check("ld_stall1", stall, 1);
        tick();
        check("ld_ctrl2", ctrl(), 3'b001);
        check("ld_last_stall", stall, 0);
        set_in(16'h1111, 16'h0, 1'b0, 1'b0, 1'b1, 4'h2);
        tick();
        check("ld_wb", wb_value_out, 16'hBEEF);
        check("ld_rw", reg_write_out, 1);
        check("ld_ra", reg_addr_out, 5);
        check("ld_idle_ctrl", ctrl(), 3'b111);
        check("ld_idle_stall", stall, 0);
        tick();
        check("ld_next_wb", wb_value_out, 16'h1111);
        check("ld_next_ra", reg_addr_out, 2);

        // Store 0x00A5 to 0x4010
        set_in(16'h4010, 16'h00A5, 1'b0, 1'b1, 1'b1, 4'h6);
        #1;
        check("st_req_stall", stall, 1);
        tick();
        check("st_setup_ctrl", ctrl(), 3'b011);
        check("st_setup_data", ram_data, 16'h00A5);
        check("st_setup_addr", ram_addr, 18'h04010);
        check("st_setup_stall", stall, 1);
        check("st_bubble", reg_write_out, 0);
        tick();
        check("st_pulse_ctrl", ctrl(), 3'b010);
        check("st_pulse_data", ram_data, 16'h00A5);
        check("st_pulse_stall", stall, 1);
        tick();
        check("st_hold_ctrl", ctrl(), 3'b011);
        check("st_hold_data", ram_data, 16'h00A5);
        check("st_hold_stall", stall, 0);
        check("st_hold_rw", reg_write_out, 0);
        set_in(16'h2222, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        check("st_exit_rw", reg_write_out, 0);
        check("st_exit_ctrl", ctrl(), 3'b111);
        check("st_mem", mem[18'h04010], 16'h00A5);

        // Back-to-back LW then SW, upstream holds its instruction while stalled
        begin
            int idx = 0, low_runs = 0, gap = 0, cur_gap = 0;
            int oe_low = 0, we_low = 0, wb_hits = 0;
            logic [15:0] wb_val = 16'h0;
            logic prev_en = 1'b1;
            logic adv;
            for (int cyc = 0; cyc < 30 && idx < 3; cyc++) begin
                set_in(prog[idx].alu, prog[idx].wval, prog[idx].rd, prog[idx].wr,
                       prog[idx].rw, prog[idx].ra);
                #1;
                if (!ram_en_n) begin
                    if (prev_en) begin
                        low_runs++;
                        if (low_runs == 2) gap = cur_gap;
                    end
                end else if (low_runs == 1) begin
                    cur_gap++;
                end
                prev_en = ram_en_n;
                if (!ram_oe_n) oe_low++;
                if (!ram_we_n) we_low++;
                adv = !stall;
                tick();
                if (reg_write_out && reg_addr_out == 4'h1) begin
                    wb_hits++;
                    wb_val = wb_value_out;
                end
                if (adv) idx++;
            end
            check("b2b_budget", idx, 3);
            check("b2b_accesses", low_runs, 2);
            check("b2b_idle_gap", gap, 1);
            check("b2b_oe_cycles", oe_low, RD_WAIT);
            check("b2b_we_cycles", we_low, WR_WAIT);
            check("b2b_wb_once", wb_hits, 1);
            check("b2b_wb_val", wb_val, 16'hCAFE);
            check("b2b_mem", mem[18'h00200], 16'h5A5A);
        end

        // Reset during the write pulse
        set_in(16'hABCD, 16'h0, 1'b0, 1'b0, 1'b1, 4'h9);
        tick();
        check("rw_pre_wb", wb_value_out, 16'hABCD);
        set_in(16'h0500, 16'h7777, 1'b0, 1'b1, 1'b1, 4'h8);
        tick();
        tick();
        check("rw_in_pulse", ram_we_n, 0);
        rst = 1'b1;
        #1;
        check("rw_stall_comb", stall, 0);
        tick();
        check("rw_ctrl", ctrl(), 3'b111);
        check("rw_stall", stall, 0);
        check("rw_wb", wb_value_out, 0);
        check("rw_rw", reg_write_out, 0);
        check("rw_ra", reg_addr_out, 0);
        check("rw_addr", ram_addr, 0);
        rst = 1'b0;
        set_in(16'h0042, 16'h0, 1'b0, 1'b0, 1'b1, 4'h1);
        #1;
        check("rw_after_stall", stall, 0);
        tick();
        check("rw_after_wb", wb_value_out, 16'h0042);
        check("rw_after_rw", reg_write_out, 1);

        // Both requests: read wins, no write strobe
        begin
            int we_low = 0;
            set_in(16'h0300, 16'hFFFF, 1'b1, 1'b1, 1'b1, 4'h4);
            #1;
            check("both_stall", stall, 1);
            for (int c = 0; c < RD_WAIT; c++) begin
                tick();
                if (!ram_we_n) we_low++;
                check("both_oe", ram_oe_n, 0);
            end
            set_in(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
            tick();
            check("both_we", we_low, 0);
            check("both_wb", wb_value_out, 16'h1357);
            check("both_rw", reg_write_out, 1);
            check("both_ra", reg_addr_out, 4);
            check("both_mem", mem[18'h00300], 16'h1357);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
